dma_mem_ctrl: RTL and testbench

DMA_MEM_CTRL -- requirements
Module: dma_mem_ctrl

---
 rtl/dma_mem_ctrl_pkg.sv | 13 +
 rtl/dma_mem_ctrl.sv | 75 +++++++
 tb/tb_dma_mem_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_mem_ctrl_pkg.sv
// Shared widths, FSM state type and default access length for the DMA memory controller.
package dma_mem_ctrl_pkg;

  localparam int unsigned ADDR_W      = 22;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ACC_CYC_DEF = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/dma_mem_ctrl.sv
// Single-slot DMA-to-memory bus controller: accepts a request, holds the memory bus
// for ACC_CYC cycles, then pulses dma_end (with read data for reads).
module dma_mem_ctrl
  import dma_mem_ctrl_pkg::*;
#(
  parameter int unsigned ACC_CYC = ACC_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_rnw,
  input  logic [DATA_W-1:0] dma_wd,
  output logic              dma_ack,
  output logic              dma_end,
  output logic [DATA_W-1:0] dma_rd,
  input  logic              cpu_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rnw,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [3:0] CNT_LAST = 4'(ACC_CYC - 1);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       last;

  assign last    = (state == ST_ACCESS) && (cnt == CNT_LAST);
  assign mem_req = (state == ST_ACCESS);

  // rst_n gates the ack because state already reads IDLE while reset is held
  always_comb begin
    dma_ack = rst_n & dma_req & ~cpu_busy & ((state == ST_IDLE) | last);
  end

  always_comb begin
    state_nx = state;
    if (dma_ack)
      state_nx = ST_ACCESS;
    else if (last)
      state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mem_addr <= '0;
      mem_rnw  <= 1'b1;
      mem_wd   <= '0;
      dma_end  <= 1'b0;
      dma_rd   <= '0;
    end else begin
      state   <= state_nx;
      dma_end <= last;
      if (last && mem_rnw)
        dma_rd <= mem_rd;
      if (dma_ack) begin
        mem_addr <= dma_addr;
        mem_rnw  <= dma_rnw;
        mem_wd   <= dma_wd;
        cnt      <= '0;
      end else if (last) begin
        mem_rnw <= 1'b1;
        cnt     <= '0;
      end else if (state == ST_ACCESS) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dma_mem_ctrl.sv
// Bench for dma_mem_ctrl: three instances (ACC_CYC = 1, 2, 3) share one directed stimulus
// stream and are compared every cycle against a remaining-cycles transaction model.
module tb_dma_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dma_req;
  logic [21:0] dma_addr;
  logic        dma_rnw;
  logic [7:0]  dma_wd;
  logic        cpu_busy;

  logic [2:0]       ack_w, end_w, mreq_w, mrnw_w;
  logic [2:0][7:0]  drd_w, mwd_w, mrd_w;
  logic [2:0][21:0] maddr_w;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dma_mem_ctrl #(.ACC_CYC(g + 1)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .dma_req  (dma_req),
      .dma_addr (dma_addr),
      .dma_rnw  (dma_rnw),
      .dma_wd   (dma_wd),
      .dma_ack  (ack_w[g]),
      .dma_end  (end_w[g]),
      .dma_rd   (drd_w[g]),
      .cpu_busy (cpu_busy),
      .mem_req  (mreq_w[g]),
      .mem_addr (maddr_w[g]),
      .mem_rnw  (mrnw_w[g]),
      .mem_wd   (mwd_w[g]),
      .mem_rd   (mrd_w[g])
    );
    // memory contents are a fixed function of address
    assign mrd_w[g] = maddr_w[g][7:0] ^ 8'hE0;
  end

  function automatic logic [7:0] memf(input logic [21:0] a);
    return a[7:0] ^ 8'hE0;
  endfunction

  // Model: rem = memory cycles still owed to the current access (0 = bus free)
  int          rem   [3];
  logic [21:0] m_addr[3];
  logic        m_rnw [3];
  logic [7:0]  m_wd  [3];
  logic [7:0]  m_rd  [3];
  logic        m_end [3];

  function automatic logic exp_ack(input int i);
    return rst_n && dma_req && !cpu_busy && (rem[i] <= 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        rem[i]    <= 0;
        m_addr[i] <= '0;
        m_rnw[i]  <= 1'b1;
        m_wd[i]   <= '0;
        m_rd[i]   <= '0;
        m_end[i]  <= 1'b0;
      end else begin
        m_end[i] <= (rem[i] == 1);
        if (rem[i] == 1 && m_rnw[i])
          m_rd[i] <= memf(m_addr[i]);
        if (exp_ack(i)) begin
          rem[i]    <= i + 1;
          m_addr[i] <= dma_addr;
          m_rnw[i]  <= dma_rnw;
          m_wd[i]   <= dma_wd;
        end else if (rem[i] != 0) begin
          rem[i] <= rem[i] - 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s inst%0d (ACC_CYC=%0d): got %0h expected %0h at t=%0t", nm, i, i + 1, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic busy_bus;
      busy_bus = (rem[i] > 0);
      chk("dma_ack", i, 32'(ack_w[i]), 32'(exp_ack(i)));
      chk("mem_req", i, 32'(mreq_w[i]), 32'(busy_bus));
      chk("mem_rnw", i, 32'(mrnw_w[i]), busy_bus ? 32'(m_rnw[i]) : 32'd1);
      chk("dma_end", i, 32'(end_w[i]), 32'(m_end[i]));
      chk("dma_rd", i, 32'(drd_w[i]), 32'(m_rd[i]));
      if (busy_bus || !rst_n) begin
        chk("mem_addr", i, 32'(maddr_w[i]), 32'(m_addr[i]));
        chk("mem_wd", i, 32'(mwd_w[i]), 32'(m_wd[i]));
      end
    end
  endtask

  task automatic cyc(input logic r, input logic q, input logic [21:0] a,
                     input logic w, input logic [7:0] d, input logic b);
    @(negedge clk);
    rst_n    = r;
    dma_req  = q;
    dma_addr = a;
    dma_rnw  = w;
    dma_wd   = d;
    cpu_busy = b;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 22'h0, 1'b1, 8'h00, 1'b0);
  endtask

  initial begin
    int na, nr, ne, ntog;
    logic prev;
    rst_n = 1'b0; dma_req = 1'b0; dma_addr = '0; dma_rnw = 1'b1; dma_wd = '0; cpu_busy = 1'b0;

    // reset state
    cyc(1'b0, 1'b0, 22'h0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 22'h0, 1'b1, 8'h00, 1'b0);
    chk("rst_ack", 1, 32'(ack_w[1]), 32'd0);
    chk("rst_mem_req", 1, 32'(mreq_w[1]), 32'd0);
    chk("rst_mem_rnw", 1, 32'(mrnw_w[1]), 32'd1);
    chk("rst_mem_addr", 1, 32'(maddr_w[1]), 32'd0);
    chk("rst_dma_rd", 1, 32'(drd_w[1]), 32'd0);
    idle(2);

    // single read, ack at T
    cyc(1'b1, 1'b1, 22'h012345, 1'b1, 8'h00, 1'b0);
    chk("rd_ack_T", 1, 32'(ack_w[1]), 32'd1);
    idle(1);
    chk("rd_mreq_T1", 1, 32'(mreq_w[1]), 32'd1);
    chk("rd_maddr_T1", 1, 32'(maddr_w[1]), 32'h012345);
    idle(1);
    chk("rd_mreq_T2", 1, 32'(mreq_w[1]), 32'd1);
    idle(1);
    chk("rd_end_T3", 1, 32'(end_w[1]), 32'd1);
    chk("rd_data_T3", 1, 32'(drd_w[1]), 32'hA5);
    chk("rd_mreq_T3", 1, 32'(mreq_w[1]), 32'd0);
    idle(3);

    // single write
    cyc(1'b1, 1'b1, 22'h3FFFFF, 1'b0, 8'h5A, 1'b0);
    chk("wr_ack_T", 1, 32'(ack_w[1]), 32'd1);
    idle(1);
    chk("wr_rnw_T1", 1, 32'(mrnw_w[1]), 32'd0);
    chk("wr_wd_T1", 1, 32'(mwd_w[1]), 32'h5A);
    chk("wr_addr_T1", 1, 32'(maddr_w[1]), 32'h3FFFFF);
    idle(1);
    chk("wr_wd_T2", 1, 32'(mwd_w[1]), 32'h5A);
    idle(1);
    chk("wr_end_T3", 1, 32'(end_w[1]), 32'd1);
    chk("wr_rd_hold", 1, 32'(drd_w[1]), 32'hA5);
    idle(3);

    // continuous reads, ACC_CYC=3 instance
    na = 0; nr = 0; ne = 0;
    for (int k = 0; k < 14; k++) begin
      cyc(1'b1, k < 12, 22'h000100 + 22'(k), 1'b1, 8'h00, 1'b0);
      na += int'(ack_w[2]); nr += int'(mreq_w[2]); ne += int'(end_w[2]);
    end
    chk("cont_acks", 2, 32'(na), 32'd4);
    chk("cont_mreq_cycles", 2, 32'(nr), 32'd12);
    chk("cont_ends", 2, 32'(ne), 32'd4);
    chk("cont_last_data", 2, 32'(drd_w[2]), 32'hE9);
    idle(3);

    // cpu_busy blocks acceptance only
    na = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b1, 22'h2AAAAA, 1'b1, 8'h00, 1'b1);
      na += int'(ack_w[1]);
    end
    chk("busy_no_ack", 1, 32'(na), 32'd0);
    cyc(1'b1, 1'b1, 22'h2AAAAA, 1'b1, 8'h00, 1'b0);
    chk("busy_release_ack", 1, 32'(ack_w[1]), 32'd1);
    cyc(1'b1, 1'b0, 22'h0, 1'b1, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 22'h0, 1'b1, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 22'h0, 1'b1, 8'h00, 1'b1);
    chk("busy_mid_end", 1, 32'(end_w[1]), 32'd1);
    chk("busy_mid_data", 1, 32'(drd_w[1]), 32'h4A);
    idle(3);

    // reset in second ACCESS cycle
    cyc(1'b1, 1'b1, 22'h155555, 1'b1, 8'h00, 1'b0);
    idle(1);
    cyc(1'b0, 1'b1, 22'h155555, 1'b1, 8'h00, 1'b0);
    chk("rmid_mreq", 1, 32'(mreq_w[1]), 32'd0);
    chk("rmid_addr", 1, 32'(maddr_w[1]), 32'd0);
    chk("rmid_rnw", 1, 32'(mrnw_w[1]), 32'd1);
    chk("rmid_ack", 1, 32'(ack_w[1]), 32'd0);
    ne = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 22'h0, 1'b1, 8'h00, 1'b0);
      ne += int'(end_w[0]) + int'(end_w[1]) + int'(end_w[2]);
    end
    chk("rmid_no_end", 1, 32'(ne), 32'd0);
    cyc(1'b1, 1'b1, 22'h0ABCDE, 1'b1, 8'h00, 1'b0);
    chk("rmid_next_ack", 1, 32'(ack_w[1]), 32'd1);
    idle(2);
    idle(1);
    chk("rmid_next_end", 1, 32'(end_w[1]), 32'd1);
    chk("rmid_next_data", 1, 32'(drd_w[1]), 32'h3E);
    idle(3);

    // ACC_CYC=1 alternating read/write stream
    na = 0; ne = 0; ntog = 0; prev = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, k < 8, 22'h001000 + 22'(k), logic'(k & 1), 8'(k * 3 + 1), 1'b0);
      na += int'(ack_w[0]); ne += int'(end_w[0]);
      if (k >= 2 && k <= 8 && mrnw_w[0] != prev) ntog++;
      prev = mrnw_w[0];
    end
    chk("alt_acks", 0, 32'(na), 32'd8);
    chk("alt_ends", 0, 32'(ne), 32'd8);
    chk("alt_rnw_toggles", 0, 32'(ntog), 32'd7);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
